// File: rtl/intdivrem_iter_pkg.sv
// Shared definitions for the iterative integer divide/remainder unit.
package intdivrem_iter_pkg;

    // Funct3 encodings: bit0 selects unsigned, bit1 selects remainder
    localparam logic [2:0] DIV_F3  = 3'b100;
    localparam logic [2:0] DIVU_F3 = 3'b101;
    localparam logic [2:0] REM_F3  = 3'b110;
    localparam logic [2:0] REMU_F3 = 3'b111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Width of the remaining-cycle counter; must hold XLEN when K=1
    function automatic int cnt_width(input int xlen);
        return $clog2(xlen / 1) + 1;
    endfunction

    // Leading-zero count of a 64-bit value (64 when the value is zero)
    function automatic logic [6:0] lzc64(input logic [63:0] x);
        logic [6:0] n;
        n = 7'd64;
        for (int i = 0; i < 64; i++) begin
            if (x[i]) n = 7'(63 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/intdivrem_iter_if.sv
// Request/response bundle between the execute stage and the divider.
interface intdivrem_iter_if #(
    parameter int XLEN = 64
) ();
    logic            Flush;
    logic            InValid;
    logic            InReady;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [2:0]      Funct3;
    logic            W64;
    logic            OutValid;
    logic            OutReady;
    logic [XLEN-1:0] Result;
    logic            Busy;

    modport master (
        output Flush, InValid, A, B, Funct3, W64, OutReady,
        input  InReady, OutValid, Result, Busy
    );

    modport slave (
        input  Flush, InValid, A, B, Funct3, W64, OutReady,
        output InReady, OutValid, Result, Busy
    );
endinterface

// File: rtl/intdivrem_iter_step.sv
// One restoring division step: shift {R,Q} left, trial-subtract the divisor.
module intdivrem_iter_step #(
    parameter int W = 64
) (
    input  logic [W:0]   i_rem,
    input  logic [W-1:0] i_quo,
    input  logic [W-1:0] i_div,
    output logic [W:0]   o_rem,
    output logic [W-1:0] o_quo
);
    logic [W+1:0] w_shifted;
    logic [W+1:0] w_diff;

    // Extra top bit on the difference acts as the borrow / sign of the trial
    assign w_shifted = {i_rem, i_quo[W-1]};
    assign w_diff    = w_shifted - {2'b00, i_div};
    assign o_rem     = w_diff[W+1] ? w_shifted[W:0] : w_diff[W:0];
    assign o_quo     = {i_quo[W-2:0], ~w_diff[W+1]};
endmodule

// File: rtl/intdivrem_iter.sv
// Iterative DIV/DIVU/REM/REMU (+ RV64 word forms), K quotient bits per cycle,
// with leading-zero skip on the dividend and valid/ready on both sides.
module intdivrem_iter
    import intdivrem_iter_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int K        = 1,
    parameter int SUPPORTW = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    intdivrem_iter_if.slave  bus
);
    localparam int              CNTW  = cnt_width(XLEN);
    localparam bit              SUPW  = (XLEN == 32) ? 1'b0 : (SUPPORTW != 0);
    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = ~(XLEN'(32'h7FFF_FFFF));

    // Word results are always sign-extended from bit 31
    function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] x, input logic word);
        return word ? XLEN'($signed(x[31:0])) : x;
    endfunction

    state_t            r_state;
    logic [XLEN:0]     r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_absb;
    logic [CNTW-1:0]   r_cnt;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_rem_op;
    logic              r_word;
    logic [XLEN-1:0]   r_result;
    logic              r_out_valid;
    logic              r_busy;

    logic              w_word, w_sgn, w_sa, w_sb, w_accept, w_in_ready;
    logic              w_b_zero, w_a_zero, w_ovf;
    logic [XLEN-1:0]   w_a_ext, w_b_ext, w_abs_a, w_abs_b;
    logic [XLEN-1:0]   w_special, w_quo_init, w_fix;
    logic [6:0]        w_lz, w_shift;
    logic [CNTW-1:0]   w_cnt_init;
    logic [XLEN:0]     w_r_chain [0:K];
    logic [XLEN-1:0]   w_q_chain [0:K];

    assign w_in_ready = reset_n & ((r_state == IDLE) | ((r_state == DONE) & bus.OutReady));
    assign w_accept   = bus.InValid & w_in_ready & ~bus.Flush;

    // Operand conditioning: width select, extension, magnitudes and signs
    assign w_word   = bus.W64 & SUPW;
    assign w_sgn    = ~bus.Funct3[0];
    assign w_a_ext  = w_word ? (w_sgn ? XLEN'($signed(bus.A[31:0])) : XLEN'(bus.A[31:0])) : bus.A;
    assign w_b_ext  = w_word ? (w_sgn ? XLEN'($signed(bus.B[31:0])) : XLEN'(bus.B[31:0])) : bus.B;
    assign w_sa     = w_sgn & w_a_ext[XLEN-1];
    assign w_sb     = w_sgn & w_b_ext[XLEN-1];
    assign w_abs_a  = w_sa ? -w_a_ext : w_a_ext;
    assign w_abs_b  = w_sb ? -w_b_ext : w_b_ext;
    assign w_b_zero = (w_b_ext == '0);
    assign w_a_zero = (w_a_ext == '0);
    assign w_ovf    = w_sgn & (w_a_ext == (w_word ? MIN_W : MIN_X)) & (&w_b_ext);

    // Results that are known at accept time without iterating
    always_comb begin
        w_special = '0;
        if (w_b_zero)
            w_special = bus.Funct3[1] ? w_a_ext : '1;
        else if (w_ovf)
            w_special = bus.Funct3[1] ? '0 : w_a_ext;
        w_special = wext(w_special, w_word);
    end

    // Leading-zero skip. Counting over the full XLEN keeps the word-mode
    // dividend top-aligned; XLEN-N is a multiple of K so the rounding agrees.
    assign w_lz       = lzc64(64'(w_abs_a) << (64 - XLEN));
    assign w_shift    = w_lz & 7'(~(K - 1));
    assign w_quo_init = w_abs_a << w_shift;

    // Remaining iterations after the skip, never fewer than one
    always_comb begin
        w_cnt_init = CNTW'((XLEN - int'(w_shift)) / K);
        if (w_cnt_init == '0) w_cnt_init = CNTW'(1);
    end

    assign w_r_chain[0] = r_rem;
    assign w_q_chain[0] = r_quo;

    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_step
            intdivrem_iter_step #(.W(XLEN)) u_step (
                .i_rem (w_r_chain[gi]),
                .i_quo (w_q_chain[gi]),
                .i_div (r_absb),
                .o_rem (w_r_chain[gi+1]),
                .o_quo (w_q_chain[gi+1])
            );
        end
    endgenerate

    // Sign fix-up and quotient/remainder select on the last chained step
    always_comb begin
        if (r_rem_op)
            w_fix = r_neg_r ? -w_r_chain[K][XLEN-1:0] : w_r_chain[K][XLEN-1:0];
        else
            w_fix = r_neg_q ? -w_q_chain[K] : w_q_chain[K];
        w_fix = wext(w_fix, r_word);
    end

    // Control FSM and datapath registers; Flush overrides everything
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_quo       <= '0;
            r_absb      <= '0;
            r_cnt       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_rem_op    <= 1'b0;
            r_word      <= 1'b0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (bus.Flush) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_accept) begin
            r_busy <= 1'b1;
            if (w_b_zero || w_ovf || w_a_zero) begin
                r_state     <= DONE;
                r_result    <= w_special;
                r_out_valid <= 1'b1;
            end else begin
                r_state     <= BUSY;
                r_out_valid <= 1'b0;
                r_rem       <= '0;
                r_quo       <= w_quo_init;
                r_absb      <= w_abs_b;
                r_cnt       <= w_cnt_init;
                r_neg_q     <= w_sgn & (w_sa ^ w_sb);
                r_neg_r     <= w_sa;
                r_rem_op    <= bus.Funct3[1];
                r_word      <= w_word;
            end
        end else begin
            case (r_state)
                BUSY: begin
                    r_rem <= w_r_chain[K];
                    r_quo <= w_q_chain[K];
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNTW'(1)) begin
                        r_state     <= DONE;
                        r_result    <= w_fix;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.OutReady) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.InReady  = w_in_ready;
    assign bus.OutValid = r_out_valid;
    assign bus.Result   = r_result;
    assign bus.Busy     = r_busy;
endmodule

// File: tb/tb_intdivrem_iter.sv
// Randomized + directed bench for intdivrem_iter (K=1 and K=4 instances).
module tb_intdivrem_iter;
    import intdivrem_iter_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    intdivrem_iter_if #(.XLEN(64)) bus1 ();
    intdivrem_iter_if #(.XLEN(64)) bus4 ();

    intdivrem_iter #(.XLEN(64), .K(1), .SUPPORTW(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
    intdivrem_iter #(.XLEN(64), .K(4), .SUPPORTW(1)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Architectural reference: RISC-V M-extension division semantics
    function automatic logic [63:0] ref_result(input logic [63:0] a, input logic [63:0] b,
                                               input logic [2:0] f3, input logic w);
        logic [31:0] q32, r32, x32;
        logic [63:0] q, r;
        int sa, sb;
        longint la, lb;
        if (w) begin
            sa = a[31:0];
            sb = b[31:0];
            if (b[31:0] == 32'd0) begin q32 = '1; r32 = a[31:0]; end
            else if (f3[0]) begin q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0]; end
            else if (sa == 32'sh8000_0000 && sb == -1) begin q32 = a[31:0]; r32 = 32'd0; end
            else begin q32 = sa / sb; r32 = sa % sb; end
            x32 = f3[1] ? r32 : q32;
            return {{32{x32[31]}}, x32};
        end
        la = a;
        lb = b;
        if (b == 64'd0) begin q = '1; r = a; end
        else if (f3[0]) begin q = a / b; r = a % b; end
        else if (la == 64'sh8000_0000_0000_0000 && lb == -1) begin q = a; r = 64'd0; end
        else begin q = la / lb; r = la % lb; end
        return f3[1] ? r : q;
    endfunction

    // Cycles from accept to first OutValid: 1 for special cases, else 1+Cnt
    function automatic int exp_lat(input logic [63:0] a, input logic [63:0] b,
                                   input logic [2:0] f3, input logic w, input int kk);
        int n, lz, s, cnt;
        logic [63:0] av, bv;
        logic sg;
        sg = !f3[0];
        n  = w ? 32 : 64;
        if (w) begin
            av = sg ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]};
            bv = sg ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]};
        end else begin
            av = a;
            bv = b;
        end
        if (bv == 64'd0 || av == 64'd0) return 1;
        if (sg && bv == '1 && av == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) return 1;
        if (sg && av[63]) av = -av;
        lz = 0;
        while (lz < n && !av[n-1-lz]) lz++;
        s   = lz - (lz % kk);
        cnt = (n - s) / kk;
        if (cnt < 1) cnt = 1;
        return 1 + cnt;
    endfunction

    task automatic rand_op(output logic [63:0] a, output logic [63:0] b,
                           output logic [2:0] f3, output logic w);
        int sel;
        sel = $urandom_range(0, 15);
        a = {$urandom, $urandom} >> $urandom_range(0, 63);
        b = {$urandom, $urandom} >> $urandom_range(0, 63);
        if ($urandom_range(0, 1) == 1) a = -a;
        if ($urandom_range(0, 1) == 1) b = -b;
        f3 = {1'b1, 2'($urandom_range(0, 3))};
        w  = 1'($urandom_range(0, 1));
        if (sel == 0) b = 64'd0;
        else if (sel == 1) a = 64'd0;
        else if (sel == 2) begin
            a = w ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
            b = '1;
            f3[0] = 1'b0;
        end
    endtask

    task automatic run1(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f3,
                        input logic w, input logic [63:0] exp, input string tag, output int lat);
        int wn;
        @(negedge clk);
        bus1.A = a; bus1.B = b; bus1.Funct3 = f3; bus1.W64 = w;
        bus1.InValid = 1'b1; bus1.OutReady = 1'b1;
        wn = 0;
        while (!bus1.InReady && wn < 100) begin @(negedge clk); wn++; end
        check_val({tag, "_rdy"}, 64'(bus1.InReady), 64'd1);
        @(posedge clk); #1;
        bus1.InValid = 1'b0;
        lat = 1;
        while (!bus1.OutValid && lat < 200) begin @(posedge clk); #1; lat++; end
        check_val({tag, "_res"}, bus1.Result, exp);
        check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat(a, b, f3, w, 1)));
        $display("K1 %s f3=%b w=%0d a=%h b=%h res=%h lat=%0d", tag, f3, w, a, b, bus1.Result, lat);
    endtask

    task automatic run4(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f3,
                        input logic w, input logic [63:0] exp, input string tag, output int lat);
        @(negedge clk);
        bus4.A = a; bus4.B = b; bus4.Funct3 = f3; bus4.W64 = w;
        bus4.InValid = 1'b1; bus4.OutReady = 1'b1;
        check_val({tag, "_rdy"}, 64'(bus4.InReady), 64'd1);
        @(posedge clk); #1;
        bus4.InValid = 1'b0;
        lat = 1;
        while (!bus4.OutValid && lat < 200) begin @(posedge clk); #1; lat++; end
        check_val({tag, "_res"}, bus4.Result, exp);
        check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat(a, b, f3, w, 4)));
        $display("K4 %s f3=%b w=%0d a=%h b=%h res=%h lat=%0d", tag, f3, w, a, b, bus4.Result, lat);
    endtask

    initial begin
        logic [63:0] a, b, r0;
        logic [2:0]  f3;
        logic        w;
        int          lat, cnt;

        bus1.Flush = 1'b0; bus1.InValid = 1'b0; bus1.OutReady = 1'b1;
        bus1.A = '0; bus1.B = '0; bus1.Funct3 = DIVU_F3; bus1.W64 = 1'b0;
        bus4.Flush = 1'b0; bus4.InValid = 1'b0; bus4.OutReady = 1'b1;
        bus4.A = '0; bus4.B = '0; bus4.Funct3 = DIVU_F3; bus4.W64 = 1'b0;

        #2;
        check_val("rst_outvalid", 64'(bus1.OutValid), 64'd0);
        check_val("rst_busy", 64'(bus1.Busy), 64'd0);
        check_val("rst_result", bus1.Result, 64'd0);
        check_val("rst_inready", 64'(bus1.InReady), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_val("post_rst_inready", 64'(bus1.InReady), 64'd1);

        run1(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, DIV_F3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, "div_m7_2", lat);
        run1(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, REM_F3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, "rem_m7_2", lat);
        run1(64'd7, 64'd2, REMU_F3, 1'b0, 64'd1, "remu_7_2", lat);
        run1(64'd5, 64'd0, DIVU_F3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, "divu_5_0", lat);
        check_val("divu_5_0_t1", 64'(lat), 64'd1);
        run1(64'd5, 64'd0, REMU_F3, 1'b0, 64'd5, "remu_5_0", lat);
        check_val("remu_5_0_t1", 64'(lat), 64'd1);
        run1(64'h8000_0000_0000_0000, '1, DIV_F3, 1'b0, 64'h8000_0000_0000_0000, "div_ovf", lat);
        run1(64'h8000_0000_0000_0000, '1, REM_F3, 1'b0, 64'd0, "rem_ovf", lat);
        run1(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, DIV_F3, 1'b1,
             64'hFFFF_FFFF_8000_0000, "divw_ovf", lat);
        run1(64'h1234_5678_8000_0000, 64'd1, DIVU_F3, 1'b1, 64'hFFFF_FFFF_8000_0000, "divuw", lat);
        run1(64'h0000_0000_FFFF_FFF9, 64'd2, REM_F3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "remw", lat);
        run1(64'd1, 64'd1, DIVU_F3, 1'b0, 64'd1, "divu_1_1", lat);
        check_val("divu_1_1_t2", 64'(lat), 64'd2);
        run1('1, 64'd3, DIVU_F3, 1'b0, 64'h5555_5555_5555_5555, "divu_max_3", lat);
        check_val("divu_max_3_t65", 64'(lat), 64'd65);

        for (int i = 0; i < 30; i++) begin
            rand_op(a, b, f3, w);
            run1(a, b, f3, w, ref_result(a, b, f3, w), $sformatf("rnd1_%0d", i), lat);
        end

        run4('1, 64'd3, DIVU_F3, 1'b0, 64'h5555_5555_5555_5555, "k4_max_3", lat);
        check_val("k4_max_3_t17", 64'(lat), 64'd17);
        for (int i = 0; i < 15; i++) begin
            rand_op(a, b, f3, w);
            run4(a, b, f3, w, ref_result(a, b, f3, w), $sformatf("rnd4_%0d", i), lat);
        end

        // Back-pressure: hold OutReady low, then release with a new request
        @(negedge clk);
        bus1.A = 64'd100; bus1.B = 64'd7; bus1.Funct3 = DIVU_F3; bus1.W64 = 1'b0;
        bus1.InValid = 1'b1; bus1.OutReady = 1'b0;
        @(posedge clk); #1;
        bus1.InValid = 1'b0;
        cnt = 0;
        while (!bus1.OutValid && cnt < 200) begin @(posedge clk); #1; cnt++; end
        check_val("hold_res", bus1.Result, 64'd14);
        r0 = bus1.Result;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val($sformatf("hold_stable_%0d", i), bus1.Result, r0);
            check_val($sformatf("hold_inready_%0d", i), 64'(bus1.InReady), 64'd0);
            check_val($sformatf("hold_valid_%0d", i), 64'(bus1.OutValid), 64'd1);
        end
        @(negedge clk);
        bus1.OutReady = 1'b1;
        bus1.A = 64'hFFFF_FFFF_FFFF_FFF9; bus1.B = 64'd2; bus1.Funct3 = DIV_F3;
        bus1.InValid = 1'b1;
        #1;
        check_val("b2b_inready", 64'(bus1.InReady), 64'd1);
        @(posedge clk); #1;
        bus1.InValid = 1'b0;
        check_val("b2b_busy", 64'(bus1.Busy), 64'd1);
        check_val("b2b_valid_drop", 64'(bus1.OutValid), 64'd0);
        cnt = 0;
        while (!bus1.OutValid && cnt < 200) begin @(posedge clk); #1; cnt++; end
        check_val("b2b_res", bus1.Result, 64'hFFFF_FFFF_FFFF_FFFD);
        $display("K1 hold_b2b res=%h", bus1.Result);

        // Flush about ten cycles into a 64-cycle operation
        @(negedge clk);
        bus1.A = '1; bus1.B = 64'd3; bus1.Funct3 = DIVU_F3;
        bus1.InValid = 1'b1;
        @(posedge clk); #1;
        bus1.InValid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus1.Flush = 1'b1;
        @(posedge clk); #1;
        bus1.Flush = 1'b0;
        check_val("flush_busy", 64'(bus1.Busy), 64'd0);
        check_val("flush_valid", 64'(bus1.OutValid), 64'd0);
        cnt = 0;
        for (int i = 0; i < 80; i++) begin @(posedge clk); #1; if (bus1.OutValid) cnt++; end
        check_val("flush_no_result", 64'(cnt), 64'd0);
        // A request presented together with Flush must be dropped
        @(negedge clk);
        bus1.A = 64'd5; bus1.B = 64'd0; bus1.Funct3 = DIVU_F3;
        bus1.InValid = 1'b1; bus1.Flush = 1'b1;
        @(posedge clk); #1;
        bus1.InValid = 1'b0; bus1.Flush = 1'b0;
        check_val("flush_drop_valid", 64'(bus1.OutValid), 64'd0);
        check_val("flush_drop_busy", 64'(bus1.Busy), 64'd0);
        $display("K1 flush done");
        run1(64'd100, 64'd7, DIV_F3, 1'b0, 64'd14, "after_flush", lat);

        // Asynchronous reset in the middle of a long operation
        @(negedge clk);
        bus1.A = '1; bus1.B = 64'd3; bus1.Funct3 = DIVU_F3;
        bus1.InValid = 1'b1;
        @(posedge clk); #1;
        bus1.InValid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("arst_valid", 64'(bus1.OutValid), 64'd0);
        check_val("arst_busy", 64'(bus1.Busy), 64'd0);
        check_val("arst_result", bus1.Result, 64'd0);
        check_val("arst_inready", 64'(bus1.InReady), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        $display("K1 async reset done");
        run1(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, REM_F3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, "after_rst", lat);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
